// File: rtl/imm_extend_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encoding and
// the branch-offset shift amount.
package imm_extend_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_e;

  localparam int BRANCH_SHIFT = 2;

endpackage : imm_extend_pkg

// File: rtl/imm_extend_core.sv
// Purely combinational immediate extender: sign/zero extension, upper-placement
// and word-aligned branch offsets.
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;

  assign sign_ext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper_ext  = {imm, {(OUT_W-IN_W){1'b0}}};
  // Bits shifted past the top are simply dropped.
  assign branch_ext = sign_ext << BRANCH_SHIFT;

  always_comb begin
    result = sign_ext;
    case (imm_mode_e'(mode))
      MODE_ZERO:   result = zero_ext;
      MODE_UPPER:  result = upper_ext;
      MODE_BRANCH: result = branch_ext;
      default:     result = sign_ext;
    endcase
  end

endmodule : imm_extend_core

// File: rtl/imm_extend_pipe.sv
// One-cycle immediate extension stage with a two-entry (main + skid) buffer so
// in_ready comes straight from a flop while still sustaining one item per cycle.
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and ready is a registered signal.
  logic [OUT_W-1:0] ext;
  logic             main_valid, main_valid_d;
  logic [OUT_W-1:0] main_data, main_data_d;
  logic             skid_valid, skid_valid_d;
  logic [OUT_W-1:0] skid_data, skid_data_d;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm    (in_imm),
    .mode   (in_mode),
    .result (ext)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = ext;
      end else begin
        // Clearing the data keeps out_data at zero whenever nothing is held.
        main_valid_d = 1'b0;
        main_data_d  = '0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_d;
      main_data  <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
      in_ready_q <= ~skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule : imm_extend_pipe
